// File: rtl/t_ff_count_ctrl.sv
// Toggle-input sequencer for an external bank of t_ff bits forming a mod-MOD counter.
// Computes the bank's T inputs from the command, FSM state and q feedback.
module t_ff_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] t_out,
    output logic             busy,
    output logic             wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   wrap_q, wrap_d;

    logic [WIDTH-1:0] lval;
    logic [WIDTH-1:0] inc_t;
    logic [WIDTH-1:0] dec_t;
    logic             up_wrap;
    logic             dn_wrap;
    logic             step_up;
    logic             step_dn;

    // Out-of-range load values saturate to the top legal count.
    always_comb begin
        lval = load_val;
        if ({1'b0, load_val} >= MOD_X) begin
            lval = MAX_V;
        end
    end

    // Ripple masks: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        inc_t    = '0;
        dec_t    = '0;
        inc_t[0] = 1'b1;
        dec_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            inc_t[i] = inc_t[i-1] & q_fb[i-1];
            dec_t[i] = dec_t[i-1] & ~q_fb[i-1];
        end
    end

    always_comb begin
        up_wrap = (q_fb >= MAX_V);
        dn_wrap = (q_fb == '0) || ({1'b0, q_fb} >= MOD_X);
        step_up = (state_q == RUN) && en && dir && !clr && !load;
        step_dn = (state_q == RUN) && en && !dir && !clr && !load;
    end

    always_comb begin
        t_out  = '0;
        wrap_d = 1'b0;
        if (!reset) begin
            t_out = '0;
        end else if (clr) begin
            t_out = q_fb;
        end else if (load) begin
            t_out = q_fb ^ lval;
        end else if (step_up) begin
            if (up_wrap) begin
                t_out  = q_fb;
                wrap_d = 1'b1;
            end else begin
                t_out = inc_t;
            end
        end else if (step_dn) begin
            if (dn_wrap) begin
                t_out  = q_fb ^ MAX_V;
                wrap_d = 1'b1;
            end else begin
                t_out = dec_t;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop || (oneshot && wrap_d)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
// Directed bench for t_ff_count_ctrl driving a behavioural t_ff bank.
// Expected q/wrap/busy go into a scoreboard queue and are popped after each edge.
module tb_t_ff_count_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic         oneshot = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic [W-1:0] t_out;
    logic         busy;
    logic         wrap;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         wrap;
        logic         busy;
        string        tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= q ^ t_out;
    end

    t_ff_count_ctrl #(.WIDTH(W), .MOD(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .dir      (dir),
        .oneshot  (oneshot),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q_fb     (q),
        .t_out    (t_out),
        .busy     (busy),
        .wrap     (wrap)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [W-1:0] eq,
                       input logic ew, input logic eb);
        exp_t e;
        e.q = eq; e.wrap = ew; e.busy = eb; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".q"}, 8'(q), 8'(e.q));
        chk({e.tag, ".wrap"}, 8'(wrap), 8'(e.wrap));
        chk({e.tag, ".busy"}, 8'(busy), 8'(e.busy));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst.t_out", 8'(t_out), 8'd0);
            chk("rst.q", 8'(q), 8'd0);
            chk("rst.busy", 8'(busy), 8'd0);
            chk("rst.wrap", 8'(wrap), 8'd0);
        end
        reset = 1'b1;

        start = 1'b1;
        cyc("start", 4'd0, 1'b0, 1'b1);
        start = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            k = i % 10;
            cyc("up", W'(k), (k == 0), 1'b1);
        end

        dir = 1'b0;
        cyc("dn", 4'd1, 1'b0, 1'b1);
        cyc("dn", 4'd0, 1'b0, 1'b1);
        cyc("dn_wrap", 4'd9, 1'b1, 1'b1);
        cyc("dn", 4'd8, 1'b0, 1'b1);
        for (int v = 7; v >= 3; v--) cyc("dn", W'(v), 1'b0, 1'b1);

        load = 1'b1; load_val = 4'd7;
        cyc("load7", 4'd7, 1'b0, 1'b1);
        load_val = 4'd12;
        cyc("load_sat", 4'd9, 1'b0, 1'b1);
        load = 1'b0;
        cyc("dn", 4'd8, 1'b0, 1'b1);

        oneshot = 1'b1; dir = 1'b1;
        cyc("os", 4'd9, 1'b0, 1'b1);
        cyc("os_wrap", 4'd0, 1'b1, 1'b0);
        cyc("os_hold", 4'd0, 1'b0, 1'b0);
        cyc("os_hold", 4'd0, 1'b0, 1'b0);
        oneshot = 1'b0; en = 1'b0;

        load = 1'b1; load_val = 4'd4;
        cyc("idle_load", 4'd4, 1'b0, 1'b0);
        load = 1'b0; clr = 1'b1;
        cyc("idle_clr", 4'd0, 1'b0, 1'b0);
        clr = 1'b0;

        start = 1'b1; stop = 1'b1;
        cyc("start_stop", 4'd0, 1'b0, 1'b0);
        stop = 1'b0; en = 1'b1;
        cyc("start_en", 4'd0, 1'b0, 1'b1);
        start = 1'b0;
        for (int v = 1; v <= 5; v++) cyc("up2", W'(v), 1'b0, 1'b1);

        reset = 1'b0;
        #1;
        chk("midrst.t_out", 8'(t_out), 8'd0);
        chk("midrst.q", 8'(q), 8'd0);
        chk("midrst.busy", 8'(busy), 8'd0);
        cyc("in_rst", 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc("post_rst", 4'd0, 1'b0, 1'b0);
        cyc("post_rst", 4'd0, 1'b0, 1'b0);

        start = 1'b1;
        cyc("restart", 4'd0, 1'b0, 1'b1);
        start = 1'b0; stop = 1'b1;
        cyc("stop_step", 4'd1, 1'b0, 1'b0);
        stop = 1'b0;
        cyc("stop_hold", 4'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
